// File: rtl/mul2_seq_pkg.sv
// Shared types and constants for the radix-4 sequential multiplier controller.
// Optional build macro used by the controller: MUL2_SEQ_ZERO_SKIP_EN.
package mul2_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a digit index; a single digit still needs one bit to count.
  function automatic int idx_w(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

  localparam int DEF_WIDTH = 8;
  localparam int DIGITS    = DEF_WIDTH / 2;
  localparam int ITERS     = DIGITS * DIGITS;
  localparam int IDX_W     = idx_w(DIGITS);

endpackage

// File: rtl/mul2_seq_ctrl_if.sv
// Operand/result handshake bundle of the sequential multiplier.
interface mul2_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/mul2x2_cell.sv
// Combinational 2-bit x 2-bit unsigned partial-product cell built from AND/XOR terms.
module mul2x2_cell (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [3:0] p
);
  logic t01, t10, t11, c1;

  assign t01 = x[0] & y[1];
  assign t10 = x[1] & y[0];
  assign t11 = x[1] & y[1];
  assign c1  = t01 & t10;

  assign p[0] = x[0] & y[0];
  assign p[1] = t01 ^ t10;
  assign p[2] = t11 ^ c1;
  assign p[3] = t11 & c1;
endmodule

// File: rtl/mul2_seq_ctrl.sv
// Sequential WIDTH x WIDTH multiplier sharing one 2x2 cell over all digit pairs.
// Build macro MUL2_SEQ_ZERO_SKIP_EN: zero operands bypass the digit iteration.
module mul2_seq_ctrl
  import mul2_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  mul2_seq_ctrl_if.slave bus
);
  localparam int DIG = WIDTH / 2;
  localparam int IW  = idx_w(DIG);
  localparam int PW  = 2 * WIDTH;

  state_t          state;
  logic [WIDTH-1:0] a_r, b_r;
  logic [IW-1:0]    i_r, j_r;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    product_r;
  logic             in_ready_r, out_valid_r, busy_r;

  logic [1:0]       a_dig, b_dig;
  logic [3:0]       pp;
  logic [IW+1:0]    sh;
  logic [PW-1:0]    acc_nxt;
  logic             last_i, last_j, accept;

  assign accept = (state == IDLE) && bus.in_valid;
  assign last_i = (i_r == IW'(DIG - 1));
  assign last_j = (j_r == IW'(DIG - 1));

  // Digit mux: pick the i-th digit of a and the j-th digit of b.
  assign a_dig = 2'(a_r >> {i_r, 1'b0});
  assign b_dig = 2'(b_r >> {j_r, 1'b0});

  mul2x2_cell u_cell (
    .x (a_dig),
    .y (b_dig),
    .p (pp)
  );

  // Digit pair weight is 4^(i+j); carry out of the top bit is dropped.
  assign sh      = {1'b0, i_r, 1'b0} + {1'b0, j_r, 1'b0};
  assign acc_nxt = acc + (PW'(pp) << sh);

  // Operands are pure data, captured only at accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= bus.a;
      b_r <= bus.b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      i_r         <= '0;
      j_r         <= '0;
      acc         <= '0;
      product_r   <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            i_r        <= '0;
            j_r        <= '0;
            acc        <= '0;
            in_ready_r <= 1'b0;
`ifdef MUL2_SEQ_ZERO_SKIP_EN
            if ((bus.a == '0) || (bus.b == '0)) begin
              state       <= DONE;
              product_r   <= '0;
              out_valid_r <= 1'b1;
            end else begin
              state  <= BUSY;
              busy_r <= 1'b1;
            end
`else
            state  <= BUSY;
            busy_r <= 1'b1;
`endif
          end
        end
        BUSY: begin
          acc <= acc_nxt;
          if (last_j) begin
            j_r <= '0;
            i_r <= i_r + 1'b1;
          end else begin
            j_r <= j_r + 1'b1;
          end
          if (last_i && last_j) begin
            state       <= DONE;
            product_r   <= acc_nxt;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
            i_r         <= '0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.product   = product_r;
  assign bus.busy      = busy_r;
endmodule
